// File: rtl/lcd_timing_ctrl_if.sv
// Pixel request / panel bus between the LCD timing controller, the picture
// generator and the panel pins.
interface lcd_timing_ctrl_if;
    logic [23:0] pix_data;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        lcd_hsync;
    logic        lcd_vsync;
    logic        lcd_de;
    logic [23:0] lcd_rgb;
    logic        frame_start;

    modport master (
        input  pix_data,
        output pix_x, pix_y, lcd_hsync, lcd_vsync, lcd_de, lcd_rgb, frame_start
    );

    modport slave (
        output pix_data,
        input  pix_x, pix_y, lcd_hsync, lcd_vsync, lcd_de, lcd_rgb, frame_start
    );
endinterface

// File: rtl/lcd_timing_ctrl.sv
// Raster timing for an RGB LCD panel: h/v counters, sync/DE decode, and
// early pixel requests so generator data lines up with DE.
module lcd_timing_ctrl #(
    parameter int H_SYNC   = 128,
    parameter int H_BACK   = 88,
    parameter int H_VALID  = 800,
    parameter int H_FRONT  = 40,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int V_VALID  = 480,
    parameter int V_FRONT  = 10,
    parameter int PIX_LAT  = 1,
    parameter int SYNC_POL = 0
) (
    input logic               clk_in,
    input logic               sys_rst_n,
    lcd_timing_ctrl_if.master lcd
);
    localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;
    localparam int H_ACT_S = H_SYNC + H_BACK;
    localparam int H_ACT_E = H_ACT_S + H_VALID;
    localparam int H_REQ_S = H_ACT_S - PIX_LAT;
    localparam int H_REQ_E = H_ACT_E - PIX_LAT;
    localparam int V_ACT_S = V_SYNC + V_BACK;
    localparam int V_ACT_E = V_ACT_S + V_VALID;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic        SYNC_ACT = 1'(SYNC_POL);

    logic [10:0] h_cnt;
    logic [10:0] v_cnt;
    logic        h_act;
    logic        h_req;
    logic        v_act;

    always_ff @(posedge clk_in or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? 11'd0 : v_cnt + 11'd1;
        end else begin
            h_cnt <= h_cnt + 11'd1;
        end
    end

    // Request window leads the active window by PIX_LAT so the generator's
    // registered reply arrives exactly on the matching DE cycle.
    always_comb begin
        h_act = (h_cnt >= 11'(H_ACT_S)) && (h_cnt < 11'(H_ACT_E));
        h_req = (h_cnt >= 11'(H_REQ_S)) && (h_cnt < 11'(H_REQ_E));
        v_act = (v_cnt >= 11'(V_ACT_S)) && (v_cnt < 11'(V_ACT_E));
    end

    assign lcd.lcd_hsync   = (h_cnt < 11'(H_SYNC)) ? SYNC_ACT : ~SYNC_ACT;
    assign lcd.lcd_vsync   = (v_cnt < 11'(V_SYNC)) ? SYNC_ACT : ~SYNC_ACT;
    assign lcd.lcd_de      = h_act && v_act;
    assign lcd.lcd_rgb     = (h_act && v_act) ? lcd.pix_data : 24'h000000;
    assign lcd.pix_x       = (h_req && v_act) ? 10'(h_cnt - 11'(H_REQ_S)) : 10'h3FF;
    assign lcd.pix_y       = (h_req && v_act) ? 10'(v_cnt - 11'(V_ACT_S)) : 10'h3FF;
    // Counters sit at 0/0 throughout reset; the strobe must stay quiet there.
    assign lcd.frame_start = sys_rst_n && (h_cnt == 11'd0) && (v_cnt == 11'd0);
endmodule

// File: tb/tb_lcd_timing_ctrl.sv
// Directed bench: default-timing instance plus two shrunken-raster instances
// (PIX_LAT=1 and PIX_LAT=2) fed by registered coordinate generators.
module tb_lcd_timing_ctrl;
    localparam int HS = 4, HB = 6, HV = 16, HF = 3, HT = 29;
    localparam int VS = 2, VB = 3, VV = 5, VF = 2, VT = 12;
    localparam int DHT = 1056, DVT = 525;

    logic clk_in = 1'b0;
    logic sys_rst_n = 1'b0;
    logic ovr = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    always #5 clk_in = ~clk_in;

    lcd_timing_ctrl_if ifd ();
    lcd_timing_ctrl_if if1 ();
    lcd_timing_ctrl_if if2 ();

    logic [23:0] gen1, gen2a, gen2b;
    always_ff @(posedge clk_in) begin
        gen1  <= {4'h0, if1.pix_y, if1.pix_x};
        gen2a <= {4'h0, if2.pix_y, if2.pix_x};
        gen2b <= gen2a;
    end

    assign ifd.pix_data = 24'hFFFFFF;
    assign if1.pix_data = ovr ? 24'hFFFFFF : gen1;
    assign if2.pix_data = ovr ? 24'hFFFFFF : gen2b;

    lcd_timing_ctrl u_dut_d (.clk_in(clk_in), .sys_rst_n(sys_rst_n), .lcd(ifd));

    lcd_timing_ctrl #(
        .H_SYNC(HS), .H_BACK(HB), .H_VALID(HV), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_VALID(VV), .V_FRONT(VF),
        .PIX_LAT(1), .SYNC_POL(0)
    ) u_dut_1 (.clk_in(clk_in), .sys_rst_n(sys_rst_n), .lcd(if1));

    lcd_timing_ctrl #(
        .H_SYNC(HS), .H_BACK(HB), .H_VALID(HV), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_VALID(VV), .V_FRONT(VF),
        .PIX_LAT(2), .SYNC_POL(0)
    ) u_dut_2 (.clk_in(clk_in), .sys_rst_n(sys_rst_n), .lcd(if2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic small_de(input int c);
        int h, v;
        h = c % HT;
        v = (c / HT) % VT;
        return (h >= HS + HB) && (h < HS + HB + HV) && (v >= VS + VB) && (v < VS + VB + VV);
    endfunction

    task automatic chk_small(input string nm, input int lat, input logic hs, input logic vs,
                             input logic de, input logic [23:0] rgb, input logic [9:0] px,
                             input logic [9:0] py, input logic fs);
        int h, v;
        logic vact, rq;
        logic [9:0] pxe, pye;
        h = cyc % HT;
        v = (cyc / HT) % VT;
        vact = (v >= 5) && (v < 10);
        rq = (h >= 10 - lat) && (h < 26 - lat) && vact;
        pxe = rq ? 10'(h - (10 - lat)) : 10'h3FF;
        pye = rq ? 10'(v - 5) : 10'h3FF;
        chk({nm, ".hsync"}, 32'(hs), (h < HS) ? 32'd0 : 32'd1);
        chk({nm, ".vsync"}, 32'(vs), (v < VS) ? 32'd0 : 32'd1);
        chk({nm, ".de"}, 32'(de), 32'(small_de(cyc)));
        chk({nm, ".rgb"}, 32'(rgb), small_de(cyc) ? {12'h0, 10'(v - 5), 10'(h - 10)} : 32'd0);
        chk({nm, ".pix_x"}, 32'(px), 32'(pxe));
        chk({nm, ".pix_y"}, 32'(py), 32'(pye));
        chk({nm, ".frame_start"}, 32'(fs), 32'((h == 0) && (v == 0)));
    endtask

    task automatic chk_def();
        int h, v;
        h = cyc % DHT;
        v = (cyc / DHT) % DVT;
        chk("d.hsync", 32'(ifd.lcd_hsync), (h < 128) ? 32'd0 : 32'd1);
        chk("d.vsync", 32'(ifd.lcd_vsync), (v < 2) ? 32'd0 : 32'd1);
        chk("d.de", 32'(ifd.lcd_de), 32'd0);
        chk("d.rgb", 32'(ifd.lcd_rgb), 32'd0);
        chk("d.pix_x", 32'(ifd.pix_x), 32'h3FF);
        chk("d.pix_y", 32'(ifd.pix_y), 32'h3FF);
        chk("d.frame_start", 32'(ifd.frame_start), 32'((h == 0) && (v == 0)));
    endtask

    task automatic chk_rst_state(input string nm, input logic hs, input logic vs, input logic de,
                                 input logic [23:0] rgb, input logic [9:0] px,
                                 input logic [9:0] py, input logic fs);
        chk({nm, ".rst_hsync"}, 32'(hs), 32'd0);
        chk({nm, ".rst_vsync"}, 32'(vs), 32'd0);
        chk({nm, ".rst_de"}, 32'(de), 32'd0);
        chk({nm, ".rst_rgb"}, 32'(rgb), 32'd0);
        chk({nm, ".rst_pix_x"}, 32'(px), 32'h3FF);
        chk({nm, ".rst_pix_y"}, 32'(py), 32'h3FF);
        chk({nm, ".rst_fs"}, 32'(fs), 32'd0);
    endtask

    task automatic chk_reset_all();
        chk_rst_state("d", ifd.lcd_hsync, ifd.lcd_vsync, ifd.lcd_de, ifd.lcd_rgb,
                      ifd.pix_x, ifd.pix_y, ifd.frame_start);
        chk_rst_state("s1", if1.lcd_hsync, if1.lcd_vsync, if1.lcd_de, if1.lcd_rgb,
                      if1.pix_x, if1.pix_y, if1.frame_start);
        chk_rst_state("s2", if2.lcd_hsync, if2.lcd_vsync, if2.lcd_de, if2.lcd_rgb,
                      if2.pix_x, if2.pix_y, if2.frame_start);
    endtask

    // Hand-computed spot values on the shrunken raster (active h 10..25, v 5..9).
    task automatic directed();
        if (cyc == 0) begin
            chk("pt.fs_d0", 32'(ifd.frame_start), 32'd1);
            chk("pt.fs_s1_0", 32'(if1.frame_start), 32'd1);
        end
        if (cyc == 131) chk("pt.de_line4", 32'(if1.lcd_de), 32'd0);
        if (cyc == 153) begin
            chk("pt.s2_first_req", 32'(if2.pix_x), 32'h000);
            chk("pt.s1_pre_req", 32'(if1.pix_x), 32'h3FF);
        end
        if (cyc == 154) begin
            chk("pt.s1_first_req", 32'(if1.pix_x), 32'h000);
            chk("pt.s1_first_row", 32'(if1.pix_y), 32'h000);
            chk("pt.s2_req1", 32'(if2.pix_x), 32'h001);
        end
        if (cyc == 156) begin
            chk("pt.s1_rgb_col1", 32'(if1.lcd_rgb), 32'h000001);
            chk("pt.s2_rgb_col1", 32'(if2.lcd_rgb), 32'h000001);
        end
        if (cyc == 169) chk("pt.s1_last_req", 32'(if1.pix_x), 32'h00F);
        if (cyc == 170) begin
            chk("pt.s1_post_req", 32'(if1.pix_x), 32'h3FF);
            chk("pt.s1_last_de", 32'(if1.lcd_de), 32'd1);
            chk("pt.s1_rgb_col15", 32'(if1.lcd_rgb), 32'h00000F);
        end
        if (cyc == 171) chk("pt.s1_de_off", 32'(if1.lcd_de), 32'd0);
        if (cyc == 270) chk("pt.s1_last_row", 32'(if1.pix_y), 32'h004);
        if (cyc == 272) chk("pt.s1_rgb_r4c1", 32'(if1.lcd_rgb), 32'h001001);
        if (cyc == 305) chk("pt.de_line10", 32'(if1.lcd_de), 32'd0);
        if (cyc == 347) chk("pt.fs_s1_347", 32'(if1.frame_start), 32'd0);
        if (cyc == 348) chk("pt.fs_s1_348", 32'(if1.frame_start), 32'd1);
        if (cyc == 127) chk("pt.d_hs127", 32'(ifd.lcd_hsync), 32'd0);
        if (cyc == 128) chk("pt.d_hs128", 32'(ifd.lcd_hsync), 32'd1);
        if (cyc == 1056) begin
            chk("pt.d_hs1056", 32'(ifd.lcd_hsync), 32'd0);
            chk("pt.d_fs1056", 32'(ifd.frame_start), 32'd0);
        end
        if (cyc == 2111) chk("pt.d_vs2111", 32'(ifd.lcd_vsync), 32'd0);
        if (cyc == 2112) chk("pt.d_vs2112", 32'(ifd.lcd_vsync), 32'd1);
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                @(negedge clk_in);
                cyc++;
            end
            ovr = !small_de(cyc);
            #1;
            chk_def();
            chk_small("s1", 1, if1.lcd_hsync, if1.lcd_vsync, if1.lcd_de, if1.lcd_rgb,
                      if1.pix_x, if1.pix_y, if1.frame_start);
            chk_small("s2", 2, if2.lcd_hsync, if2.lcd_vsync, if2.lcd_de, if2.lcd_rgb,
                      if2.pix_x, if2.pix_y, if2.frame_start);
            directed();
        end
    endtask

    initial begin
        sys_rst_n = 1'b0;
        ovr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            #1;
            chk_reset_all();
        end
        @(negedge clk_in);
        sys_rst_n = 1'b1;
        cyc = 0;
        run_cycles(2200);

        // Mid-frame reset, held across three rising edges.
        @(negedge clk_in);
        sys_rst_n = 1'b0;
        ovr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk_in);
            #1;
            chk_reset_all();
        end
        @(negedge clk_in);
        sys_rst_n = 1'b1;
        cyc = 0;
        run_cycles(400);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
